// File: rtl/div_seq_if.sv
// Handshake/result bundle for the sequential 8/4 restoring divider.
// master: drives init/A/B, reads results; slave: the divider side.
interface div_seq_if;
  logic       init;
  logic [7:0] A;
  logic [3:0] B;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       done;
  logic       busy;
  logic       dz;

  modport master (
    output init, A, B,
    input  quotient, remainder, done, busy, dz
  );

  modport slave (
    input  init, A, B,
    output quotient, remainder, done, busy, dz
  );
endinterface

// File: rtl/div_seq.sv
// Sequential restoring divider, 8-bit dividend / 4-bit divisor, 1 bit/clk.
// Ports: clk, rst (async active-low), bus (div_seq_if.slave).
module div_seq (
  input  logic       clk,
  input  logic       rst,
  div_seq_if.slave   bus
);

  localparam int N_A = 8;
  localparam int N_B = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_nxt;
  logic           r_init_q;
  logic [N_A-1:0] r_q;
  logic [N_B-1:0] r_d;
  logic [N_B:0]   r_r;
  logic [3:0]     r_cnt;
  logic [N_A-1:0] r_quot;
  logic [N_B-1:0] r_rem;
  logic           r_dz;

  logic           w_start;
  logic [N_B:0]   w_t;
  logic [N_B:0]   w_dx;
  logic           w_ge;
  logic [N_B:0]   w_r_nxt;
  logic [N_A-1:0] w_q_nxt;

  assign w_start = bus.init & ~r_init_q;

  // Trial value is 5 bits wide: it can reach 2*D-1.
  assign w_t     = {r_r[N_B-1:0], r_q[N_A-1]};
  assign w_dx    = {1'b0, r_d};
  assign w_ge    = (w_t >= w_dx);
  assign w_r_nxt = w_ge ? (w_t - w_dx) : w_t;
  assign w_q_nxt = {r_q[N_A-2:0], w_ge};

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_start) w_nxt = S_LOAD;
      S_LOAD: w_nxt = (bus.B == '0) ? S_DONE : S_ITER;
      S_ITER: if (r_cnt == 4'd1) w_nxt = S_DONE;
      S_DONE: w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_init_q <= 1'b0;
      r_q      <= '0;
      r_d      <= '0;
      r_r      <= '0;
      r_cnt    <= '0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_dz     <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_init_q <= bus.init;
      unique case (r_state)
        S_LOAD: begin
          if (bus.B == '0) begin
            r_quot <= '1;
            r_rem  <= '1;
            r_dz   <= 1'b1;
          end else begin
            r_q   <= bus.A;
            r_d   <= bus.B;
            r_r   <= '0;
            r_cnt <= 4'd8;
          end
        end
        S_ITER: begin
          r_q   <= w_q_nxt;
          r_r   <= w_r_nxt;
          r_cnt <= r_cnt - 4'd1;
          // Final iteration: publish results on the same edge.
          if (r_cnt == 4'd1) begin
            r_quot <= w_q_nxt;
            r_rem  <= w_r_nxt[N_B-1:0];
            r_dz   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient  = r_quot;
  assign bus.remainder = r_rem;
  assign bus.dz        = r_dz;
  assign bus.done      = (r_state == S_DONE);
  assign bus.busy      = (r_state == S_LOAD) || (r_state == S_ITER);

endmodule
